// File: rtl/calcu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calcu_pkg
// Purpose  : Opcodes, flag bit positions and FSM states shared by the calculator.
// Revision : 1.0 - initial release
// ============================================================================
package calcu_pkg;

    typedef enum logic [3:0] {
        OP_SUM  = 4'd0,
        OP_REST = 4'd1,
        OP_MOD  = 4'd2,
        OP_MULT = 4'd3,
        OP_DIV  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_LSH  = 4'd8,
        OP_RSH  = 4'd9
    } op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MOD) || (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/calcu_if.sv
`default_nettype none
// ============================================================================
// Module   : calcu_if
// Purpose  : Operand/result handshake bundle between the calculator and its peers.
// Revision : 1.0 - initial release
// ============================================================================
interface calcu_if #(parameter int N = 4);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   seleccion;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] salida;
    logic [3:0]   flags;
    logic         busy;

    modport master (
        output in_valid, a, b, seleccion, out_ready,
        input  in_ready, out_valid, salida, flags, busy
    );

    modport slave (
        input  in_valid, a, b, seleccion, out_ready,
        output in_ready, out_valid, salida, flags, busy
    );

endinterface
`default_nettype wire

// File: rtl/calcu_iter.sv
`default_nettype none
// ============================================================================
// Module   : calcu_iter
// Purpose  : Shared N-step shift-add multiplier / restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module calcu_iter
    import calcu_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         start,
    input  wire logic         mode,      // 0 multiply, 1 divide
    input  wire logic [N-1:0] a,
    input  wire logic [N-1:0] b,
    output logic              done,
    output logic [N-1:0]      lo_nxt,    // product low / quotient
    output logic [N-1:0]      hi_nxt     // product high / remainder
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_b;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          r_mode;

    logic [N:0]    w_add;
    logic [N:0]    w_sh;
    logic [N-1:0]  w_diff;
    logic          w_ge;

    // {r_hi, r_lo} acts as one 2N-bit register: shifted right for multiply, left for divide.
    always_comb begin
        w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(N+1){1'b0}});
        w_sh   = {r_hi, r_lo[N-1]};
        w_ge   = (w_sh >= {1'b0, r_b});
        w_diff = w_sh[N-1:0] - r_b;
        if (r_mode) begin
            hi_nxt = w_ge ? w_diff : w_sh[N-1:0];
            lo_nxt = {r_lo[N-2:0], w_ge};
        end else begin
            hi_nxt = w_add[N:1];
            lo_nxt = {w_add[0], r_lo[N-1:1]};
        end
    end

    assign done = r_run && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_mode <= 1'b0;
        end else if (start) begin
            r_hi   <= '0;
            r_lo   <= a;
            r_b    <= b;
            r_cnt  <= CW'(N - 1);
            r_run  <= 1'b1;
            r_mode <= mode;
        end else if (r_run) begin
            r_hi <= hi_nxt;
            r_lo <= lo_nxt;
            if (r_cnt == '0) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/calcu_seq.sv
`default_nettype none
// ============================================================================
// Module   : calcu_seq
// Purpose  : Clocked N-bit calculator with NZCV flags and valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module calcu_seq
    import calcu_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    calcu_if.slave    bus
);

    state_e       r_state;
    logic [N-1:0] r_salida;
    logic [3:0]   r_flags;
    logic [3:0]   r_op;
    logic         r_bz;

    logic         w_xfer;
    logic         w_start;
    logic         w_done;
    logic [N-1:0] w_lo;
    logic [N-1:0] w_hi;
    logic [N:0]   w_sum;
    logic [N:0]   w_dif;
    logic [N:0]   w_lsh;
    logic [N:0]   w_rsh;
    logic         w_big;
    logic [N-1:0] w_res;
    logic         w_c;
    logic         w_v;
    logic [N-1:0] w_it_res;
    logic         w_it_c;
    logic         w_it_v;

    function automatic logic [3:0] mk_flags(input logic [N-1:0] s, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = s[N-1];
        f[FLAG_Z] = (s == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign w_xfer  = bus.in_valid && (r_state == IDLE);
    assign w_start = w_xfer && is_iter(bus.seleccion);

    calcu_iter #(.N(N)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_start),
        .mode   (bus.seleccion != OP_MULT),
        .a      (bus.a),
        .b      (bus.b),
        .done   (w_done),
        .lo_nxt (w_lo),
        .hi_nxt (w_hi)
    );

    // Shift vectors carry one guard bit that holds the last bit shifted out.
    always_comb begin
        w_sum = {1'b0, bus.a} + {1'b0, bus.b};
        w_dif = {1'b0, bus.a} - {1'b0, bus.b};
        w_lsh = {1'b0, bus.a} << bus.b;
        w_rsh = {bus.a, 1'b0} >> bus.b;
        w_big = (33'(bus.b) >= 33'(N));
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.seleccion)
            OP_SUM: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (bus.a[N-1] == bus.b[N-1]) && (w_sum[N-1] != bus.a[N-1]);
            end
            OP_REST: begin
                w_res = w_dif[N-1:0];
                w_c   = w_dif[N];
                w_v   = (bus.a[N-1] != bus.b[N-1]) && (w_dif[N-1] != bus.a[N-1]);
            end
            OP_AND: w_res = bus.a & bus.b;
            OP_OR:  w_res = bus.a | bus.b;
            OP_XOR: w_res = bus.a ^ bus.b;
            OP_LSH: if (!w_big) begin
                w_res = w_lsh[N-1:0];
                w_c   = w_lsh[N];
            end
            OP_RSH: if (!w_big) begin
                w_res = w_rsh[N:1];
                w_c   = w_rsh[0];
            end
            default: ;
        endcase
    end

    assign w_it_res = (r_op == OP_MOD) ? w_hi : w_lo;
    assign w_it_c   = (r_op == OP_MULT) && (w_hi != '0);
    assign w_it_v   = (r_op != OP_MULT) && r_bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_salida <= '0;
            r_flags  <= '0;
            r_op     <= '0;
            r_bz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_xfer) begin
                    r_op <= bus.seleccion;
                    r_bz <= (bus.b == '0);
                    if (w_start) begin
                        r_state <= BUSY;
                    end else begin
                        r_salida <= w_res;
                        r_flags  <= mk_flags(w_res, w_c, w_v);
                        r_state  <= DONE;
                    end
                end
                BUSY: if (w_done) begin
                    r_salida <= w_it_res;
                    r_flags  <= mk_flags(w_it_res, w_it_c, w_it_v);
                    r_state  <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rst_n && (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == BUSY);
    assign bus.salida    = r_salida;
    assign bus.flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_calcu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_calcu_seq
// Purpose  : Directed table-driven bench for calcu_seq at N=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calcu_seq;

    localparam int N  = 4;
    localparam int NV = 21;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    calcu_if #(.N(N)) bus ();

    calcu_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] s;
        logic [3:0]   f;
        int           lat;
    } vec_t;

    vec_t tbl [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int k;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.seleccion = op;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept_wait", 32'(k < 20), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(output logic [N-1:0] s, output logic [3:0] f, output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        s = bus.salida;
        f = bus.flags;
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] s;
        logic [3:0]   f;
        int           lat;
        int           bc;

        //            op     a      b      salida flags    lat
        tbl[0]  = '{4'd0,  4'd7,  4'd1,  4'd8,  4'b1001, 1};
        tbl[1]  = '{4'd0,  4'd7,  4'd9,  4'd0,  4'b0110, 1};
        tbl[2]  = '{4'd1,  4'd3,  4'd5,  4'd14, 4'b1010, 1};
        tbl[3]  = '{4'd1,  4'd8,  4'd1,  4'd7,  4'b0001, 1};
        tbl[4]  = '{4'd3,  4'd5,  4'd3,  4'd15, 4'b1000, 5};
        tbl[5]  = '{4'd3,  4'd6,  4'd3,  4'd2,  4'b0010, 5};
        tbl[6]  = '{4'd3,  4'd15, 4'd15, 4'd1,  4'b0010, 5};
        tbl[7]  = '{4'd4,  4'd13, 4'd4,  4'd3,  4'b0000, 5};
        tbl[8]  = '{4'd2,  4'd13, 4'd4,  4'd1,  4'b0000, 5};
        tbl[9]  = '{4'd4,  4'd9,  4'd0,  4'd15, 4'b1001, 5};
        tbl[10] = '{4'd2,  4'd9,  4'd0,  4'd9,  4'b1001, 5};
        tbl[11] = '{4'd4,  4'd15, 4'd1,  4'd15, 4'b1000, 5};
        tbl[12] = '{4'd5,  4'd12, 4'd10, 4'd8,  4'b1000, 1};
        tbl[13] = '{4'd6,  4'd12, 4'd3,  4'd15, 4'b1000, 1};
        tbl[14] = '{4'd7,  4'd5,  4'd5,  4'd0,  4'b0100, 1};
        tbl[15] = '{4'd8,  4'd11, 4'd1,  4'd6,  4'b0010, 1};
        tbl[16] = '{4'd9,  4'd11, 4'd2,  4'd2,  4'b0010, 1};
        tbl[17] = '{4'd9,  4'd11, 4'd5,  4'd0,  4'b0100, 1};
        tbl[18] = '{4'd8,  4'd11, 4'd4,  4'd0,  4'b0100, 1};
        tbl[19] = '{4'd8,  4'd11, 4'd0,  4'd11, 4'b1000, 1};
        tbl[20] = '{4'd12, 4'd7,  4'd3,  4'd0,  4'b0100, 1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.seleccion = '0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_salida",    32'(bus.salida),    32'd0);
        chk("rst_flags",     32'(bus.flags),     32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        for (int i = 0; i < NV; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            collect(s, f, lat, bc);
            chk($sformatf("v%0d_salida", i), 32'(s), 32'(tbl[i].s));
            chk($sformatf("v%0d_flags", i), 32'(f), 32'(tbl[i].f));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), (tbl[i].lat == 5) ? 32'd4 : 32'd0);
            release_out();
        end

        // Backpressure: result held, new request ignored until the DONE handshake.
        issue(4'd0, 4'd3, 4'd4);
        collect(s, f, lat, bc);
        chk("bp_first_salida", 32'(s), 32'd7);
        chk("bp_first_flags",  32'(f), 32'd0);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 4'd15;
        bus.b         = 4'd1;
        bus.seleccion = 4'd7;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_salida", k),   32'(bus.salida),    32'd7);
            chk($sformatf("bp_hold%0d_flags", k),    32'(bus.flags),     32'd0);
            chk($sformatf("bp_hold%0d_in_ready", k), 32'(bus.in_ready),  32'd0);
            chk($sformatf("bp_hold%0d_valid", k),    32'(bus.out_valid), 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_idle_in_ready", 32'(bus.in_ready),  32'd1);
        chk("bp_idle_valid",    32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        collect(s, f, lat, bc);
        chk("bp_second_salida",  32'(s),   32'd14);
        chk("bp_second_flags",   32'(f),   32'b1000);
        chk("bp_second_latency", 32'(lat), 32'd1);
        release_out();

        // Reset during the second BUSY cycle of a division.
        issue(4'd4, 4'd13, 4'd4);
        @(posedge clk);
        #2;
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy",   32'(bus.busy),      32'd0);
        chk("mid_rst_salida", 32'(bus.salida),    32'd0);
        chk("mid_rst_flags",  32'(bus.flags),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'd3, 4'd5, 4'd3);
        collect(s, f, lat, bc);
        chk("post_rst_salida",  32'(s),   32'd15);
        chk("post_rst_flags",   32'(f),   32'b1000);
        chk("post_rst_latency", 32'(lat), 32'd5);
        release_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
